// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised SRAM.
// Optional parity storage is enabled by defining SRAM_PARITY_EN.
package sram_pkg;

  typedef enum logic [0:0] {
    StClear,
    StIdle
  } sram_state_e;

  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/sram_clear_seq.sv
// Sweep counter for the clear sequencer: restarts on start, advances while active,
// flags the last word of the array.
module sram_clear_seq
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              start,
  input  logic              active,
  output logic [ADDR_W-1:0] cnt,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (active && (cnt_q != LastIdx)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q == LastIdx);

endmodule

// File: rtl/sram_param.sv
// Parametrised single-port SRAM with registered read, valid strobe and clear-on-reset sweep.
// Defining SRAM_PARITY_EN adds a stored even-parity bit, par_flip and parity_err.
module sram_param
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d_in,
  input  logic              clr,
`ifdef SRAM_PARITY_EN
  input  logic              par_flip,
  output logic              parity_err,
`endif
  output logic              ready,
  output logic [DATA_W-1:0] d_out,
  output logic              d_valid
);

`ifdef SRAM_PARITY_EN
  localparam int unsigned WordW = DATA_W + 1;
`else
  localparam int unsigned WordW = DATA_W;
`endif
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DepthL = (ADDR_W + 1)'(DEPTH);

  sram_state_e state_q, state_d;
  logic [DATA_W-1:0] d_out_q, d_out_d;
  logic              d_valid_q, d_valid_d;

  logic [WordW-1:0] mem [DEPTH];
  logic [WordW-1:0] wr_word, rd_word;
  logic [IdxW-1:0]  wr_idx;
  logic             wr_en;

  logic              idle, clearing, clr_acc, acc, rd_fire, in_range, seq_done;
  logic [ADDR_W-1:0] seq_cnt;

  assign idle     = (state_q == StIdle);
  assign clearing = (state_q == StClear);
  assign clr_acc  = idle & clr & ~rst;
  // clr wins over a simultaneous request
  assign acc      = idle & req & ~clr & ~rst;
  assign rd_fire  = acc & ~we;
  assign in_range = ({1'b0, addr} < DepthL);

  sram_clear_seq #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_clear_seq (
    .clk   (clk),
    .start (rst | clr_acc),
    .active(clearing),
    .cnt   (seq_cnt),
    .done  (seq_done)
  );

  always_comb begin
    state_d = state_q;
    if (rst) begin
      state_d = StClear;
    end else begin
      unique case (state_q)
        StClear: if (seq_done) state_d = StIdle;
        StIdle:  if (clr) state_d = StClear;
        default: state_d = StClear;
      endcase
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = addr[IdxW-1:0];
    wr_word = '0;
    if (clearing) begin
      wr_en  = 1'b1;
      wr_idx = seq_cnt[IdxW-1:0];
    end else if (acc && we && in_range) begin
      wr_en = 1'b1;
`ifdef SRAM_PARITY_EN
      wr_word = {even_parity(64'(d_in)) ^ par_flip, d_in};
`else
      wr_word = d_in;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_word;
    end
  end

  assign rd_word = mem[addr[IdxW-1:0]];

  always_comb begin
    d_out_d   = d_out_q;
    d_valid_d = rd_fire;
    if (rst) begin
      d_out_d = '0;
    end else if (rd_fire) begin
      d_out_d = in_range ? rd_word[DATA_W-1:0] : '0;
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    d_out_q   <= d_out_d;
    d_valid_q <= d_valid_d;
  end

`ifdef SRAM_PARITY_EN
  logic parity_err_q, parity_err_d;

  always_comb begin
    parity_err_d = 1'b0;
    if (rd_fire && in_range) begin
      parity_err_d = even_parity(64'(rd_word[DATA_W-1:0])) ^ rd_word[DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`endif

  assign ready   = idle;
  assign d_out   = d_out_q;
  assign d_valid = d_valid_q;

endmodule

// File: tb/tb_sram_param.sv
// Directed self-checking bench for sram_param: DEPTH=16 and DEPTH=12 instances.
// Parity checks are included when SRAM_PARITY_EN is defined.
module tb_sram_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_req = 0, a_we = 0, a_clr = 0;
  logic [3:0] a_addr = 0;
  logic [7:0] a_d_in = 0;
  logic       a_ready, a_d_valid;
  logic [7:0] a_d_out;

  logic       b_req = 0, b_we = 0, b_clr = 0;
  logic [3:0] b_addr = 0;
  logic [7:0] b_d_in = 0;
  logic       b_ready, b_d_valid;
  logic [7:0] b_d_out;

`ifdef SRAM_PARITY_EN
  logic a_par_flip = 0, a_parity_err;
  logic b_par_flip = 0, b_parity_err;
`endif

  int checks   = 0;
  int failures = 0;

  sram_param #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .req       (a_req),
    .we        (a_we),
    .addr      (a_addr),
    .d_in      (a_d_in),
    .clr       (a_clr),
`ifdef SRAM_PARITY_EN
    .par_flip  (a_par_flip),
    .parity_err(a_parity_err),
`endif
    .ready     (a_ready),
    .d_out     (a_d_out),
    .d_valid   (a_d_valid)
  );

  sram_param #(.ADDR_W(4), .DATA_W(8), .DEPTH(12)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .req       (b_req),
    .we        (b_we),
    .addr      (b_addr),
    .d_in      (b_d_in),
    .clr       (b_clr),
`ifdef SRAM_PARITY_EN
    .par_flip  (b_par_flip),
    .parity_err(b_parity_err),
`endif
    .ready     (b_ready),
    .d_out     (b_d_out),
    .d_valid   (b_d_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset state
    cyc(2);
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_d_out", 32'(a_d_out), 32'h0);
    chk("rst_d_valid", 32'(a_d_valid), 32'd0);
`ifdef SRAM_PARITY_EN
    chk("rst_parity_err", 32'(a_parity_err), 32'd0);
`endif
    rst = 1'b0;

    // Sweep after reset release: cycle 1 .. DEPTH low, ready in DEPTH+1
    for (int k = 1; k <= 17; k++) begin
      chk($sformatf("sweep_a_ready_c%0d", k), 32'(a_ready), 32'(k == 17));
      chk($sformatf("sweep_b_ready_c%0d", k), 32'(b_ready), 32'(k >= 13));
      if (k < 17) cyc(1);
    end

    // Read every word back as zero, d_valid continuously high
    a_req = 1; a_we = 0;
    for (int i = 0; i < 16; i++) begin
      a_addr = 4'(i);
      cyc(1);
      chk($sformatf("clr_rd_valid_%0d", i), 32'(a_d_valid), 32'd1);
      chk($sformatf("clr_rd_data_%0d", i), 32'(a_d_out), 32'h0);
    end
    a_req = 0;
    cyc(1);
    chk("rd_valid_drop", 32'(a_d_valid), 32'd0);

    // Write then read next cycle; hold afterwards
    a_req = 1; a_we = 1; a_addr = 4'd3; a_d_in = 8'hA5;
    cyc(1);
    chk("wr_no_valid", 32'(a_d_valid), 32'd0);
    a_we = 0;
    cyc(1);
    chk("raw_valid", 32'(a_d_valid), 32'd1);
    chk("raw_data", 32'(a_d_out), 32'hA5);
    a_req = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk($sformatf("hold_data_%0d", i), 32'(a_d_out), 32'hA5);
      chk($sformatf("hold_valid_%0d", i), 32'(a_d_valid), 32'd0);
    end

    // clr beats a simultaneous read; memory zeroed, d_out untouched
    a_req = 1; a_we = 1; a_addr = 4'd5; a_d_in = 8'h3C;
    cyc(1);
    a_we = 0; a_clr = 1;
    cyc(1);
    a_req = 0; a_clr = 0;
    for (int k = 1; k <= 17; k++) begin
      chk($sformatf("clr_ready_c%0d", k), 32'(a_ready), 32'(k == 17));
      chk($sformatf("clr_valid_c%0d", k), 32'(a_d_valid), 32'd0);
      if (k < 17) cyc(1);
    end
    chk("clr_keeps_d_out", 32'(a_d_out), 32'hA5);
    a_req = 1; a_addr = 4'd5;
    cyc(1);
    a_req = 0;
    chk("clr_rd5_valid", 32'(a_d_valid), 32'd1);
    chk("clr_rd5_data", 32'(a_d_out), 32'h0);

    // rst in IDLE with a read in flight discards the strobe
    a_req = 1; a_we = 1; a_addr = 4'd3; a_d_in = 8'h11;
    cyc(1);
    a_we = 0; rst = 1;
    cyc(1);
    rst = 0; a_req = 0;
    chk("rst_idle_valid", 32'(a_d_valid), 32'd0);
    chk("rst_idle_d_out", 32'(a_d_out), 32'h0);
    chk("rst_idle_ready", 32'(a_ready), 32'd0);

    // rst in cycle 7 of the sweep restarts it
    cyc(6);
    chk("mid_clr_ready_c7", 32'(a_ready), 32'd0);
    rst = 1;
    cyc(1);
    rst = 0;
    for (int k = 1; k <= 17; k++) begin
      chk($sformatf("restart_ready_c%0d", k), 32'(a_ready), 32'(k == 17));
      if (k < 17) cyc(1);
    end

    // DEPTH=12: out-of-range write dropped, read returns 0 with valid
    b_req = 1; b_we = 1; b_addr = 4'd11; b_d_in = 8'h5A;
    cyc(1);
    b_we = 0;
    cyc(1);
    chk("b_rd11_valid", 32'(b_d_valid), 32'd1);
    chk("b_rd11_data", 32'(b_d_out), 32'h5A);
    b_we = 1; b_addr = 4'd13; b_d_in = 8'hFF;
    cyc(1);
    b_we = 0;
    cyc(1);
    chk("b_rd13_valid", 32'(b_d_valid), 32'd1);
    chk("b_rd13_data", 32'(b_d_out), 32'h0);
    b_addr = 4'd11;
    cyc(1);
    b_req = 0;
    chk("b_rd11_again", 32'(b_d_out), 32'h5A);

`ifdef SRAM_PARITY_EN
    a_req = 1; a_we = 1; a_addr = 4'd2; a_d_in = 8'h07; a_par_flip = 1;
    cyc(1);
    a_addr = 4'd4; a_par_flip = 0;
    cyc(1);
    a_we = 0; a_addr = 4'd2;
    cyc(1);
    chk("par_rd2_data", 32'(a_d_out), 32'h07);
    chk("par_rd2_err", 32'(a_parity_err), 32'd1);
    a_addr = 4'd4;
    cyc(1);
    a_req = 0;
    chk("par_rd4_data", 32'(a_d_out), 32'h07);
    chk("par_rd4_err", 32'(a_parity_err), 32'd0);
    cyc(1);
    chk("par_idle_err", 32'(a_parity_err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
